seg_display_ctrl: RTL and testbench

Parametrised, bus-attached multiplexed seven-segment display controller, successor to the fixed 4-digit hex display peripheral. Holds a write/read-back value register and a control register. Scans `DIGITS` common-select digits at a programmable slot rate, with:
- per-digit decimal points and blanking,
- leading-zero suppression,
- 16-level brightness PWM.

It sits on the CPU's peripheral bus next to the other I/O devices and drives the board display pins directly.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_hex_decoder.sv | 19 +
 rtl/seg_display_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared constants for the multiplexed seven-segment display
//               controller. Holds the register map, the CTRL field positions
//               and the active-high hex glyph table {a,b,c,d,e,f,g}.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Register map
  localparam logic [1:0] SEG_ADR_VALUE  = 2'd0;
  localparam logic [1:0] SEG_ADR_CTRL   = 2'd1;
  localparam logic [1:0] SEG_ADR_STATUS = 2'd2;

  // CTRL field positions
  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_LZS_BIT    = 1;
  localparam int CTRL_BRIGHT_LSB = 4;
  localparam int CTRL_DP_LSB     = 8;
  localparam int CTRL_BLANK_LSB  = 16;

  // Hex glyphs, active-high, bit 6 = segment a ... bit 0 = segment g
  localparam logic [6:0] SEG_GLYPHS [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decoder
// Description : Combinational nibble to seven-segment glyph lookup.
// Ports       : nibble - 4-bit hex digit
//               glyph  - active-high segments {a,b,c,d,e,f,g}
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = SEG_GLYPHS[nibble];

endmodule
`default_nettype wire

// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_ctrl
// Description : Bus-attached multiplexed seven-segment display controller with
//               per-digit dp/blanking, leading-zero suppression and 16-level
//               brightness PWM.
// Ports       : clk, rst (async, active-low)
//               WE_I, ADR_I, DAT_I - register write port
//               DAT_O              - registered read data (1-cycle latency)
//               seg, seg_dp        - segment pins (polarity per SEG_ACTIVE_LOW)
//               seg_sel            - one-hot active-high digit select
// Revision    : 1.0 - initial release
// ============================================================================
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 5000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              WE_I,
  input  logic [1:0]        ADR_I,
  input  logic [31:0]       DAT_I,
  output logic [31:0]       DAT_O,
  output logic [6:0]        seg,
  output logic              seg_dp,
  output logic [DIGITS-1:0] seg_sel
);

  // The prescaler is kept as {phase, sub_cnt}: phase is the PWM phase and
  // sub_cnt counts the CLK_DIV/16 clocks spent in each phase.
  localparam int              PHASE_DIV  = CLK_DIV / 16;
  localparam int              SW         = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam logic [SW-1:0]   SUB_LAST   = SW'(PHASE_DIV - 1);
  localparam logic [2:0]      LAST_IDX   = 3'(DIGITS - 1);
  localparam logic [31:0]     VALUE_MASK = 32'((64'd1 << (4 * DIGITS)) - 64'd1);
  localparam logic [7:0]      DIGIT_MASK = 8'((16'd1 << DIGITS) - 16'd1);
  localparam logic [6:0]      SEG_OFF    = {7{SEG_ACTIVE_LOW}};

  // Registers
  logic [31:0]   value;
  logic          en;
  logic          lzs;
  logic [3:0]    bright;
  logic [7:0]    dp_mask;
  logic [7:0]    blank_mask;

  // Scan state
  logic [SW-1:0] sub_cnt;
  logic [3:0]    phase;
  logic [2:0]    idx;
  logic [7:0]    frame;

  // Slot latch for the digit currently being shown (digit idx)
  logic [3:0]    lat_nib;
  logic          lat_dp;
  logic          lat_vis;

  logic          slot_end;
  logic [2:0]    nxt_idx;
  logic [7:0]    upper_zero;
  logic          nxt_vis;
  logic [6:0]    glyph;
  logic          show;
  logic [31:0]   rd_data;

  assign slot_end = (phase == 4'd15) && (sub_cnt == SUB_LAST);
  assign nxt_idx  = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;

  // upper_zero[i]: nibble i and every nibble above it are zero
  for (genvar i = 0; i < 8; i++) begin : g_lz
    assign upper_zero[i] = ~|value[31:4*i];
  end

  assign nxt_vis = en & ~blank_mask[nxt_idx]
                 & ~(lzs & (nxt_idx != 3'd0) & upper_zero[nxt_idx]);

  // ---------------- bus registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value      <= '0;
      en         <= 1'b1;
      lzs        <= 1'b0;
      bright     <= 4'hF;
      dp_mask    <= '0;
      blank_mask <= '0;
    end else if (WE_I) begin
      if (ADR_I == SEG_ADR_VALUE) begin
        value <= DAT_I & VALUE_MASK;
      end else if (ADR_I == SEG_ADR_CTRL) begin
        en         <= DAT_I[CTRL_EN_BIT];
        lzs        <= DAT_I[CTRL_LZS_BIT];
        bright     <= DAT_I[CTRL_BRIGHT_LSB +: 4];
        dp_mask    <= DAT_I[CTRL_DP_LSB +: 8] & DIGIT_MASK;
        blank_mask <= DAT_I[CTRL_BLANK_LSB +: 8] & DIGIT_MASK;
      end
    end
  end

  // ---------------- scan counters and slot latch ----------------
  // The latch loads the next digit on the same edge the index advances, so it
  // samples register contents from before any write on that edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_cnt <= '0;
      phase   <= '0;
      idx     <= '0;
      frame   <= '0;
      lat_nib <= '0;
      lat_dp  <= 1'b0;
      lat_vis <= 1'b1;  // digit 0 of the reset register contents is visible
    end else begin
      if (sub_cnt == SUB_LAST) begin
        sub_cnt <= '0;
        phase   <= phase + 4'd1;
      end else begin
        sub_cnt <= sub_cnt + SW'(1);
      end
      if (slot_end) begin
        idx     <= nxt_idx;
        if (nxt_idx == 3'd0) begin
          frame <= frame + 8'd1;
        end
        lat_nib <= value[{nxt_idx, 2'b00} +: 4];
        lat_dp  <= dp_mask[nxt_idx];
        lat_vis <= nxt_vis;
      end
    end
  end

  seg_hex_decoder u_dec (
    .nibble (lat_nib),
    .glyph  (glyph)
  );

  // EN is applied here as well so that disabling blanks the pins right away
  // instead of waiting for the next slot.
  assign show = lat_vis & en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg     <= SEG_OFF;
      seg_dp  <= SEG_ACTIVE_LOW;
      seg_sel <= '0;
    end else begin
      seg     <= show ? (glyph ^ SEG_OFF) : SEG_OFF;
      seg_dp  <= (show & lat_dp) ^ SEG_ACTIVE_LOW;
      seg_sel <= (show && (phase <= bright)) ? (DIGITS'(1) << idx) : '0;
    end
  end

  // ---------------- read port ----------------
  always_comb begin
    rd_data = '0;
    case (ADR_I)
      SEG_ADR_VALUE:  rd_data = value;
      SEG_ADR_CTRL:   rd_data = {8'h00, blank_mask, dp_mask, bright, 2'b00, lzs, en};
      SEG_ADR_STATUS: rd_data = {16'h0000, frame, 5'b00000, idx};
      default:        rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DAT_O <= '0;
    end else begin
      DAT_O <= rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_ctrl
// Description : Directed self-checking bench for seg_display_ctrl with
//               DIGITS=4, CLK_DIV=16, active-low segments.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        WE_I;
  logic [1:0]  ADR_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  seg_sel;

  int n_assert = 0;
  int n_fail   = 0;
  int n        = 0;  // posedges since the last reset release
  int on_cnt;

  // Active-low glyphs for the hex digits used below
  localparam logic [6:0] G0 = 7'h01;  // ~1111110
  localparam logic [6:0] G1 = 7'h4F;  // ~0110000
  localparam logic [6:0] G2 = 7'h12;  // ~1101101
  localparam logic [6:0] G4 = 7'h4C;  // ~0110011
  localparam logic [6:0] GA = 7'h08;  // ~1110111
  localparam logic [6:0] GF = 7'h38;  // ~1000111
  localparam logic [6:0] OFF = 7'h7F;

  seg_display_ctrl #(
    .DIGITS         (4),
    .CLK_DIV        (16),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .WE_I    (WE_I),
    .ADR_I   (ADR_I),
    .DAT_I   (DAT_I),
    .DAT_O   (DAT_O),
    .seg     (seg),
    .seg_dp  (seg_dp),
    .seg_sel (seg_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int k);
    repeat (k) @(negedge clk);
    n += k;
  endtask

  task automatic adv_to(input int target);
    adv(target - n);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    WE_I  = 1'b1;
    ADR_I = a;
    DAT_I = d;
    adv(1);
    WE_I  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; WE_I = 1'b0; ADR_I = 2'd0; DAT_I = '0;
    repeat (3) @(negedge clk);
    chk("rst_seg",   seg,     OFF);
    chk("rst_dp",    seg_dp,  1);
    chk("rst_sel",   seg_sel, 0);
    chk("rst_dato",  DAT_O,   0);
    rst = 1'b1;
    n = 0;

    // Scan from reset
    adv_to(1);  chk("scan1_sel", seg_sel, 4'b0001); chk("scan1_seg", seg, G0);
                chk("scan1_dp", seg_dp, 1);         chk("scan1_dato", DAT_O, 0);
    adv_to(16); chk("scan16_sel", seg_sel, 4'b0001);
    adv_to(17); chk("scan17_sel", seg_sel, 4'b0010);
    adv_to(33); chk("scan33_sel", seg_sel, 4'b0100);
    adv_to(49); chk("scan49_sel", seg_sel, 4'b1000); chk("scan49_seg", seg, G0);
    adv_to(65); chk("scan65_sel", seg_sel, 4'b0001);

    // VALUE write and read-back; upper bits are not stored
    wr(2'd0, 32'hFFFF_12AF);
    adv_to(67); chk("rd_value", DAT_O, 32'h0000_12AF);
    adv_to(81);  chk("d1_sel", seg_sel, 4'b0010); chk("d1_seg", seg, GA);
    adv_to(97);  chk("d2_sel", seg_sel, 4'b0100); chk("d2_seg", seg, G2);
    adv_to(113); chk("d3_sel", seg_sel, 4'b1000); chk("d3_seg", seg, G1);
    adv_to(129); chk("d0_sel", seg_sel, 4'b0001); chk("d0_seg", seg, GF);

    // Write on a slot-boundary edge is not seen by that slot
    adv_to(143);
    wr(2'd0, 32'h0000_0040);
    adv_to(145); chk("bnd_sel", seg_sel, 4'b0010); chk("bnd_seg_old", seg, GA);

    // Leading-zero suppression
    wr(2'd1, 32'h0000_00F3);
    adv_to(161); chk("lzs_d2_sel", seg_sel, 0); chk("lzs_d2_seg", seg, OFF);
    adv_to(177); chk("lzs_d3_sel", seg_sel, 0);
    adv_to(193); chk("lzs_d0_sel", seg_sel, 4'b0001); chk("lzs_d0_seg", seg, G0);
    adv_to(209); chk("lzs_d1_sel", seg_sel, 4'b0010); chk("lzs_d1_seg", seg, G4);

    // Brightness 3: 4 of 16 clocks in digit 0's slot
    wr(2'd1, 32'h0000_0033);
    adv_to(256);
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      adv(1);
      if (seg_sel != 4'b0000) on_cnt++;
    end
    chk("pwm_on_clocks", on_cnt, 4);

    // EN=0 drops the select one cycle after the write; scan keeps running
    wr(2'd1, 32'h0000_00F0);
    adv_to(274); chk("en0_sel", seg_sel, 0);
    ADR_I = 2'd2;
    adv_to(300); chk("en0_status_a", DAT_O, 32'h0000_0402); chk("en0_sel_b", seg_sel, 0);
    adv_to(330); chk("en0_status_b", DAT_O, 32'h0000_0500);

    // DP/BLANK masks, unused mask bits read 0; address 3 ignored
    wr(2'd1, 32'h0038_F5F1);
    adv_to(332); chk("rd_ctrl", DAT_O, 32'h0008_05F1);
    wr(2'd3, 32'hDEAD_BEEF);
    adv_to(334); chk("rd_adr3", DAT_O, 0);
    adv_to(337); chk("m_d1_dp", seg_dp, 1); chk("m_d1_seg", seg, G4);
    adv_to(353); chk("m_d2_dp", seg_dp, 0); chk("m_d2_sel", seg_sel, 4'b0100);
                 chk("m_d2_seg", seg, G0);
    adv_to(369); chk("m_d3_sel", seg_sel, 0); chk("m_d3_seg", seg, OFF);
                 chk("m_d3_dp", seg_dp, 1);
    adv_to(385); chk("m_d0_dp", seg_dp, 0); chk("m_d0_sel", seg_sel, 4'b0001);

    // Asynchronous reset mid-slot
    ADR_I = 2'd1;
    adv_to(390);
    #2 rst = 1'b0;
    #1;
    chk("arst_seg",  seg,     OFF);
    chk("arst_dp",   seg_dp,  1);
    chk("arst_sel",  seg_sel, 0);
    chk("arst_dato", DAT_O,   0);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    adv_to(1); chk("post_rst_ctrl", DAT_O, 32'h0000_00F1);
               chk("post_rst_sel", seg_sel, 4'b0001);

    // Frame counter
    ADR_I = 2'd2;
    adv_to(193);   chk("frame3",   DAT_O, 32'h0000_0300);
    adv_to(16384); chk("frame255", DAT_O, 32'h0000_FF03);
    adv_to(16385); chk("frame_wrap", DAT_O, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
